// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // A single-bit counter is still needed when WIDTH is 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level one-bit full subtractor, companion to the gate-level adder cells.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire a_xor_b;
    wire a_n;
    wire a_xnor_b;
    wire borrow_gen;
    wire borrow_prop;

    xor g_x1 (a_xor_b, a, b);
    xor g_x2 (d, a_xor_b, bin);

    // Borrow is generated when a=0,b=1, and propagated when a==b.
    not g_n1 (a_n, a);
    and g_a1 (borrow_gen, a_n, b);
    not g_n2 (a_xnor_b, a_xor_b);
    and g_a2 (borrow_prop, a_xnor_b, bin);
    or  g_o1 (bout, borrow_gen, borrow_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             bflop;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bflop),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Shift written this way so it stays legal when WIDTH is 1.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bflop  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        bflop  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    bflop  <= bout;
                    cnt    <= cnt + 1'b1;
                    // Outputs only change on the final bit, never mid-operation.
                    if (cnt == LAST) begin
                        diff   <= res_next;
                        borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] last_diff;
    logic       last_borrow;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns in cycle 1 of the operation.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        tick();
        start8 = 1'b0;
    endtask

    task automatic runOperation(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] exp_diff, input logic exp_borrow);
        applyStimulus(a, b);
        for (int c = 1; c <= 8; c++) begin
            checkOutput({tag, " busy"}, 32'(busy8), 32'd1);
            checkOutput({tag, " done early"}, 32'(done8), 32'd0);
            checkOutput({tag, " diff held"}, 32'(diff8), 32'(last_diff));
            checkOutput({tag, " borrow held"}, 32'(borrow8), 32'(last_borrow));
            tick();
        end
        checkOutput({tag, " done"}, 32'(done8), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy8), 32'd1);
        checkOutput({tag, " diff"}, 32'(diff8), 32'(exp_diff));
        checkOutput({tag, " borrow"}, 32'(borrow8), 32'(exp_borrow));
        last_diff   = exp_diff;
        last_borrow = exp_borrow;
        tick();
        checkOutput({tag, " done cleared"}, 32'(done8), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        rst    = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        a8     = '0;
        b8     = '0;
        a1     = '0;
        b1     = '0;
        tick();
        tick();
        checkOutput("reset busy", 32'(busy8), 32'd0);
        checkOutput("reset done", 32'(done8), 32'd0);
        checkOutput("reset diff", 32'(diff8), 32'd0);
        checkOutput("reset borrow", 32'(borrow8), 32'd0);
        checkOutput("reset busy w1", 32'(busy1), 32'd0);
        rst         = 1'b0;
        last_diff   = 8'd0;
        last_borrow = 1'b0;
        tick();

        runOperation("200-55", 8'd200, 8'd55, 8'd145, 1'b0);
        runOperation("5-10", 8'd5, 8'd10, 8'd251, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("5-10 diff kept", 32'(diff8), 32'd251);
            checkOutput("5-10 borrow kept", 32'(borrow8), 32'd1);
        end

        // A second start while busy must be ignored.
        applyStimulus(8'd9, 8'd3);
        tick();
        tick();
        tick();
        start8 = 1'b1;
        a8     = 8'd1;
        b8     = 8'd2;
        checkOutput("busy-start diff held", 32'(diff8), 32'd251);
        tick();
        start8 = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            checkOutput("busy-start done early", 32'(done8), 32'd0);
            checkOutput("busy-start diff held", 32'(diff8), 32'd251);
            tick();
        end
        checkOutput("busy-start done", 32'(done8), 32'd1);
        checkOutput("busy-start diff", 32'(diff8), 32'd6);
        checkOutput("busy-start borrow", 32'(borrow8), 32'd0);
        last_diff   = 8'd6;
        last_borrow = 1'b0;
        tick();
        checkOutput("busy-start idle", 32'(busy8), 32'd0);

        runOperation("0-0", 8'd0, 8'd0, 8'd0, 1'b0);
        runOperation("255-0", 8'd255, 8'd0, 8'd255, 1'b0);
        runOperation("0-255", 8'd0, 8'd255, 8'd1, 1'b1);
        runOperation("128-128", 8'd128, 8'd128, 8'd0, 1'b0);
        runOperation("3-200", 8'd3, 8'd200, 8'd59, 1'b1);

        // Reset in the middle of an operation aborts it.
        applyStimulus(8'd100, 8'd1);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort busy", 32'(busy8), 32'd0);
        checkOutput("abort done", 32'(done8), 32'd0);
        checkOutput("abort diff", 32'(diff8), 32'd0);
        checkOutput("abort borrow", 32'(borrow8), 32'd0);
        rst         = 1'b0;
        last_diff   = 8'd0;
        last_borrow = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checkOutput("abort no done", 32'(done8), 32'd0);
            tick();
        end
        runOperation("7-7", 8'd7, 8'd7, 8'd0, 1'b0);

        // Start held high: the next operation begins on the first IDLE edge.
        start8 = 1'b1;
        a8     = 8'd50;
        b8     = 8'd20;
        tick();
        for (int c = 1; c <= 8; c++) tick();
        checkOutput("held done 1", 32'(done8), 32'd1);
        checkOutput("held diff 1", 32'(diff8), 32'd30);
        a8 = 8'd20;
        b8 = 8'd50;
        tick();
        checkOutput("held idle gap", 32'(busy8), 32'd0);
        tick();
        checkOutput("held restart", 32'(busy8), 32'd1);
        start8 = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        checkOutput("held done 2", 32'(done8), 32'd1);
        checkOutput("held diff 2", 32'(diff8), 32'd226);
        checkOutput("held borrow 2", 32'(borrow8), 32'd1);
        last_diff   = 8'd226;
        last_borrow = 1'b1;
        tick();

        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            runOperation("sweep8", ra, rb, 8'(ra - rb), (ra < rb));
        end

        for (int i = 0; i < 500; i++) begin
            a1     = 1'($urandom_range(0, 1));
            b1     = 1'($urandom_range(0, 1));
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checkOutput("sweep1 busy", 32'(busy1), 32'd1);
            checkOutput("sweep1 done early", 32'(done1), 32'd0);
            tick();
            checkOutput("sweep1 done", 32'(done1), 32'd1);
            checkOutput("sweep1 diff", 32'(diff1), 32'(1'(a1 - b1)));
            checkOutput("sweep1 borrow", 32'(borrow1), 32'(a1 < b1));
            tick();
            checkOutput("sweep1 idle", 32'(busy1), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
